// File: rtl/conv_pkg.sv
// Shared types and geometry defaults for the 3x3 convolution window sequencer.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        STREAM,
        DONE
    } seq_state_t;

    // Counter width needed to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_BITWIDTH     = 8;
    localparam int DEF_FILTER_WIDTH = 3;
    localparam int DEF_IMG_WIDTH    = 28;
    localparam int DEF_IMG_HEIGHT   = 28;

    localparam int DEF_ROW_W = cnt_width(DEF_IMG_HEIGHT);
    localparam int DEF_COL_W = cnt_width(DEF_IMG_WIDTH);

endpackage

// File: rtl/raster_pos_counter.sv
// Raster-order column/row position of the next pixel to be accepted.
module raster_pos_counter
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = DEF_IMG_WIDTH,
    parameter int IMG_HEIGHT = DEF_IMG_HEIGHT,
    parameter int COL_W      = DEF_COL_W,
    parameter int ROW_W      = DEF_ROW_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             advance,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             row_end,
    output logic             last
);

    assign row_end = (col == COL_W'(IMG_WIDTH - 1));
    assign last    = row_end && (row == ROW_W'(IMG_HEIGHT - 1));

    // Step one pixel per advance; wrap columns into the next row, never past the last row.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (row_end) begin
                col <= '0;
                if (!last) begin
                    row <= row + 1'b1;
                end
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_window_sequencer.sv
// Frame sequencer for the sliding-window convolution datapath: accepts a raster
// pixel stream, drives line-buffer enables and tags complete windows.
module conv_window_sequencer
    import conv_pkg::*;
#(
    parameter int bitwidth    = DEF_BITWIDTH,
    parameter int filterWidth = DEF_FILTER_WIDTH,
    parameter int imgWidth    = DEF_IMG_WIDTH,
    parameter int imgHeight   = DEF_IMG_HEIGHT
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    input  logic                            abort,
    input  logic                            pix_valid,
    output logic                            pix_ready,
    output logic [filterWidth-2:0]          buf_wr_en,
    output logic [filterWidth-2:0]          buf_rd_en,
    output logic                            win_valid,
    output logic [cnt_width(imgHeight)-1:0] out_row,
    output logic [cnt_width(imgWidth)-1:0]  out_col,
    output logic                            busy,
    output logic                            done
);

    localparam int ROW_W = cnt_width(imgHeight);
    localparam int COL_W = cnt_width(imgWidth);
    localparam int CNT_W = cnt_width(imgWidth * imgHeight + 1);
    localparam int DEPTH = imgWidth - filterWidth;
    localparam int OCC_W = cnt_width(DEPTH + 1);

    // Pixel width only matters to the datapath; an illegal geometry elaborates
    // this empty marker block so it shows up in the hierarchy.
    if (bitwidth < 1 || imgWidth <= filterWidth || imgHeight < filterWidth) begin : g_bad_geometry
    end

    seq_state_t       state_reg;
    seq_state_t       state_next;
    logic             clear;
    logic             acc;
    logic             win_hit;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;
    logic             row_end;
    logic             last_pixel;
    logic [CNT_W-1:0] count_reg;
    logic             win_valid_reg;
    logic [ROW_W-1:0] out_row_reg;
    logic [COL_W-1:0] out_col_reg;

    // Ready drops while abort is high so an aborted pixel is never counted as taken.
    assign pix_ready = ((state_reg == FILL) || (state_reg == STREAM)) && !abort;
    assign acc       = pix_valid && pix_ready;
    assign busy      = (state_reg == FILL) || (state_reg == STREAM);
    assign done      = (state_reg == DONE);

    raster_pos_counter #(
        .IMG_WIDTH (imgWidth),
        .IMG_HEIGHT(imgHeight),
        .COL_W     (COL_W),
        .ROW_W     (ROW_W)
    ) u_pos (
        .clock  (clock),
        .reset  (reset),
        .clear  (clear),
        .advance(acc),
        .row    (row),
        .col    (col),
        .row_end(row_end),
        .last   (last_pixel)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; clear restarts all counters on a new frame or an abort.
    always_comb begin
        state_next = state_reg;
        clear      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = FILL;
                    clear      = 1'b1;
                end
            end
            FILL: begin
                if (abort) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end else if (acc && row_end && (row == ROW_W'(filterWidth - 2))) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (abort) begin
                    state_next = IDLE;
                    clear      = 1'b1;
                end else if (acc && last_pixel) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Number of pixels accepted so far this frame; drives the line-buffer write thresholds.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (acc) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    // One line buffer per filter row except the newest: writes begin once enough
    // pixels have streamed past it, reads begin when it holds a full row gap.
    for (genvar gi = 0; gi < filterWidth - 1; gi++) begin : g_lbuf
        localparam int THRESH = (gi + 1) * filterWidth + gi * DEPTH;
        logic [OCC_W-1:0] occ_reg;

        assign buf_wr_en[gi] = acc && (count_reg >= CNT_W'(THRESH));
        assign buf_rd_en[gi] = acc && (occ_reg == OCC_W'(DEPTH));

        // Occupancy fills on writes and saturates at the buffer depth.
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                occ_reg <= '0;
            end else if (clear) begin
                occ_reg <= '0;
            end else if (buf_wr_en[gi] && (occ_reg != OCC_W'(DEPTH))) begin
                occ_reg <= occ_reg + 1'b1;
            end
        end
    end

    // Windows exist only once filterWidth rows and columns are in; no row-wrap windows.
    assign win_hit = acc && (row >= ROW_W'(filterWidth - 1)) && (col >= COL_W'(filterWidth - 1));

    // Window flag and output coordinates, one cycle after the completing pixel.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            win_valid_reg <= 1'b0;
            out_row_reg   <= '0;
            out_col_reg   <= '0;
        end else begin
            win_valid_reg <= win_hit;
            if (win_hit) begin
                out_row_reg <= row - ROW_W'(filterWidth - 1);
                out_col_reg <= col - COL_W'(filterWidth - 1);
            end
        end
    end

    assign win_valid = win_valid_reg;
    assign out_row   = out_row_reg;
    assign out_col   = out_col_reg;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Directed bench: 5x5 frame with a 3x3 filter, plus a default 28x28 instance.
module tb_conv_window_sequencer;

    logic       clock     = 1'b0;
    logic       reset     = 1'b1;
    logic       start     = 1'b0;
    logic       abort     = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_ready;
    logic [1:0] buf_wr_en;
    logic [1:0] buf_rd_en;
    logic       win_valid;
    logic [2:0] out_row;
    logic [2:0] out_col;
    logic       busy;
    logic       done;

    logic       start28     = 1'b0;
    logic       abort28     = 1'b0;
    logic       pix_valid28 = 1'b0;
    logic       pix_ready28;
    logic [1:0] wr28;
    logic [1:0] rd28;
    logic       win28;
    logic [4:0] row28;
    logic [4:0] col28;
    logic       busy28;
    logic       done28;

    int vectors     = 0;
    int miscompares = 0;

    // Per-frame capture filled by run_frame.
    int acc_count, nwin, ndone, stall_bad, ready_bad, prev_pixel, done_pixel;
    int win_row[16];
    int win_col[16];
    int win_pixel[16];
    int first_wr[2];
    int first_rd[2];
    int n_wr[2];
    int n_rd[2];

    always #5 clock = ~clock;

    conv_window_sequencer #(
        .bitwidth(8), .filterWidth(3), .imgWidth(5), .imgHeight(5)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .abort(abort),
        .pix_valid(pix_valid), .pix_ready(pix_ready),
        .buf_wr_en(buf_wr_en), .buf_rd_en(buf_rd_en),
        .win_valid(win_valid), .out_row(out_row), .out_col(out_col),
        .busy(busy), .done(done)
    );

    conv_window_sequencer dut28 (
        .clock(clock), .reset(reset), .start(start28), .abort(abort28),
        .pix_valid(pix_valid28), .pix_ready(pix_ready28),
        .buf_wr_en(wr28), .buf_rd_en(rd28),
        .win_valid(win28), .out_row(row28), .out_col(col28),
        .busy(busy28), .done(done28)
    );

    // Drive one cycle of inputs at the falling edge and settle before sampling.
    task automatic step(input logic v, input logic s, input logic a);
        @(negedge clock);
        pix_valid = v;
        start     = s;
        abort     = a;
        #1;
    endtask

    // Start a 5x5 frame and stream it, recording windows, done and enable activity.
    task automatic run_frame(input bit toggle, input int start_at_pixel);
        logic v;
        logic s;
        acc_count = 0; nwin = 0; ndone = 0; stall_bad = 0; ready_bad = 0;
        prev_pixel = -1; done_pixel = -1;
        for (int i = 0; i < 16; i++) begin
            win_row[i] = -1; win_col[i] = -1; win_pixel[i] = -1;
        end
        for (int k = 0; k < 2; k++) begin
            first_wr[k] = -1; first_rd[k] = -1; n_wr[k] = 0; n_rd[k] = 0;
        end
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 70; i++) begin
            v = (acc_count < 25) && (!toggle || (i % 2 == 0));
            s = (start_at_pixel >= 0) && (acc_count == start_at_pixel);
            step(v, s, 1'b0);
            if (win_valid) begin
                if (nwin < 16) begin
                    win_row[nwin] = int'(out_row);
                    win_col[nwin] = int'(out_col);
                    win_pixel[nwin] = prev_pixel;
                end
                nwin++;
            end
            if (done) begin
                ndone++;
                done_pixel = prev_pixel;
            end
            if (ndone > 0 && pix_ready) ready_bad++;
            if (!v && (buf_wr_en != 2'b00 || buf_rd_en != 2'b00)) stall_bad++;
            if (toggle && v && win_valid) stall_bad++;
            for (int k = 0; k < 2; k++) begin
                if (buf_wr_en[k]) begin
                    if (first_wr[k] < 0) first_wr[k] = acc_count;
                    n_wr[k]++;
                end
                if (buf_rd_en[k]) begin
                    if (first_rd[k] < 0) first_rd[k] = acc_count;
                    n_rd[k]++;
                end
            end
            if (v && pix_ready) begin
                prev_pixel = acc_count;
                acc_count++;
            end else begin
                prev_pixel = -1;
            end
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        vectors++;
        if ({pix_ready, busy, done} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_status: got ready/busy/done=%b required 000", {pix_ready, busy, done});
        end
        vectors++;
        if ({buf_wr_en, buf_rd_en} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_enables: got wr=%b rd=%b required 00/00", buf_wr_en, buf_rd_en);
        end
        vectors++;
        if ({win_valid, out_row, out_col} !== 7'd0) begin
            miscompares++;
            $display("FAIL reset_window: got win=%b row=%0d col=%0d required 0", win_valid, out_row, out_col);
        end
        @(negedge clock);
        reset = 1'b0;
        // Frame interrupted by reset right after pixel 12 completes the first window.
        step(1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 13; p++) step(1'b1, 1'b0, 1'b0);
        @(negedge clock);
        #1;
        vectors++;
        if (win_valid !== 1'b1 || out_row !== 3'd0 || out_col !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_prewin: got win=%b (%0d,%0d) required 1 (0,0)", win_valid, out_row, out_col);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({pix_ready, buf_wr_en, buf_rd_en, win_valid, busy, done} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_async: got ready=%b wr=%b rd=%b win=%b busy=%b done=%b required all 0",
                     pix_ready, buf_wr_en, buf_rd_en, win_valid, busy, done);
        end
        @(negedge clock);
        reset = 1'b0;
        pix_valid = 1'b0;
        run_frame(1'b0, -1);
        vectors++;
        if (nwin != 9 || ndone != 1) begin
            miscompares++;
            $display("FAIL reset_refill: got windows=%0d dones=%0d required 9 and 1", nwin, ndone);
        end
    endtask

    task automatic test_full_stream;
        run_frame(1'b0, -1);
        vectors++;
        if (nwin != 9) begin
            miscompares++;
            $display("FAIL stream_count: got %0d windows required 9", nwin);
        end
        vectors++;
        if (win_pixel[0] != 12 || win_row[0] != 0 || win_col[0] != 0) begin
            miscompares++;
            $display("FAIL stream_first: got pixel %0d (%0d,%0d) required pixel 12 (0,0)",
                     win_pixel[0], win_row[0], win_col[0]);
        end
        vectors++;
        if (win_row[8] != 2 || win_col[8] != 2) begin
            miscompares++;
            $display("FAIL stream_last: got (%0d,%0d) required (2,2)", win_row[8], win_col[8]);
        end
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (win_row[i] != i / 3 || win_col[i] != i % 3 || win_pixel[i] != 12 + (i / 3) * 5 + i % 3) begin
                miscompares++;
                $display("FAIL stream_seq[%0d]: got (%0d,%0d) after pixel %0d required (%0d,%0d) after pixel %0d",
                         i, win_row[i], win_col[i], win_pixel[i], i / 3, i % 3, 12 + (i / 3) * 5 + i % 3);
            end
        end
        vectors++;
        if (ndone != 1 || done_pixel != 24) begin
            miscompares++;
            $display("FAIL stream_done: got %0d pulses after pixel %0d required 1 after pixel 24", ndone, done_pixel);
        end
        vectors++;
        if (ready_bad != 0 || pix_ready !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL stream_idle: got ready_after_done=%0d ready=%b busy=%b required 0", ready_bad, pix_ready, busy);
        end
    endtask

    task automatic test_stall;
        run_frame(1'b1, -1);
        vectors++;
        if (nwin != 9 || acc_count != 25) begin
            miscompares++;
            $display("FAIL stall_count: got %0d windows %0d pixels required 9 and 25", nwin, acc_count);
        end
        for (int i = 0; i < 9; i++) begin
            vectors++;
            if (win_row[i] != i / 3 || win_col[i] != i % 3 || win_pixel[i] != 12 + (i / 3) * 5 + i % 3) begin
                miscompares++;
                $display("FAIL stall_seq[%0d]: got (%0d,%0d) after pixel %0d required (%0d,%0d)",
                         i, win_row[i], win_col[i], win_pixel[i], i / 3, i % 3);
            end
        end
        vectors++;
        if (stall_bad != 0) begin
            miscompares++;
            $display("FAIL stall_quiet: got %0d stall-cycle activity events required 0", stall_bad);
        end
        vectors++;
        if (ndone != 1) begin
            miscompares++;
            $display("FAIL stall_done: got %0d done pulses required 1", ndone);
        end
    endtask

    task automatic test_enable_timing;
        run_frame(1'b0, -1);
        vectors++;
        if (first_wr[0] != 3 || first_rd[0] != 5) begin
            miscompares++;
            $display("FAIL enable_buf0: got wr first %0d rd first %0d required 3 and 5", first_wr[0], first_rd[0]);
        end
        vectors++;
        if (first_wr[1] != 8 || first_rd[1] != 10) begin
            miscompares++;
            $display("FAIL enable_buf1: got wr first %0d rd first %0d required 8 and 10", first_wr[1], first_rd[1]);
        end
        vectors++;
        if (n_wr[0] != 22 || n_rd[0] != 20 || n_wr[1] != 17 || n_rd[1] != 15) begin
            miscompares++;
            $display("FAIL enable_counts: got wr0=%0d rd0=%0d wr1=%0d rd1=%0d required 22 20 17 15",
                     n_wr[0], n_rd[0], n_wr[1], n_rd[1]);
        end
    endtask

    task automatic test_abort;
        int n;
        int d;
        int lr;
        int lc;
        bit saw_done;
        step(1'b0, 1'b1, 1'b0);
        for (int p = 0; p < 17; p++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (busy !== 1'b0 || win_valid !== 1'b0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_idle: got busy=%b win=%b done=%b required 0 0 0", busy, win_valid, done);
        end
        saw_done = 1'b0;
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0);
            if (done) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL abort_nodone: got done pulse required none");
        end
        // Full default-geometry frame on the second instance.
        @(negedge clock);
        start28 = 1'b1;
        @(negedge clock);
        start28 = 1'b0;
        pix_valid28 = 1'b1;
        n = 0; d = 0; lr = -1; lc = -1;
        for (int i = 0; i < 900; i++) begin
            @(negedge clock);
            #1;
            if (win28) begin
                n++;
                lr = int'(row28);
                lc = int'(col28);
            end
            if (done28) d++;
        end
        pix_valid28 = 1'b0;
        vectors++;
        if (n != 676) begin
            miscompares++;
            $display("FAIL frame28_count: got %0d windows required 676", n);
        end
        vectors++;
        if (d != 1 || lr != 25 || lc != 25) begin
            miscompares++;
            $display("FAIL frame28_end: got dones=%0d last=(%0d,%0d) required 1 (25,25)", d, lr, lc);
        end
    endtask

    task automatic test_start_abort_corners;
        bit saw_done;
        run_frame(1'b0, 14);
        vectors++;
        if (nwin != 9 || ndone != 1 || done_pixel != 24 || acc_count != 25) begin
            miscompares++;
            $display("FAIL start_ignored: got windows=%0d dones=%0d done_after=%0d pixels=%0d required 9 1 24 25",
                     nwin, ndone, done_pixel, acc_count);
        end
        // start and abort together in IDLE: the frame must begin.
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL start_wins: got busy=%b required 1", busy);
        end
        for (int p = 0; p < 24; p++) step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0 || win_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_last: got done=%b busy=%b win=%b required 0 0 0", done, busy, win_valid);
        end
        saw_done = 1'b0;
        repeat (3) begin
            step(1'b0, 1'b0, 1'b0);
            if (done) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done) begin
            miscompares++;
            $display("FAIL abort_last_nodone: got done pulse required none");
        end
    endtask

    initial begin
        test_reset();
        test_full_stream();
        test_stall();
        test_enable_timing();
        test_abort();
        test_start_abort_corners();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
